// File: rtl/flash_page_writer.sv
// Page-buffered sequencer feeding the SPI flash controller command port:
// optional chip erase, one page program per 256 buffered bytes, then END.
package spi_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, ERASE = 2'd1, WRITE = 2'd2, END = 2'd3} cmd_t;
endpackage

module flash_page_writer #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter bit          ERASE_EN  = 1'b1,
  parameter logic [7:0]  PAD_BYTE  = 8'hFF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output spi_pkg::cmd_t       cmd,
  input  logic                cmd_done,
  output logic [23:0]         addr_in,
  input  logic [23:0]         addr_out,
  output logic [7:0]          data_in,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         pages_written
);
  typedef enum logic [3:0] {
    S_IDLE, S_ERASE_REQ, S_ERASE_WAIT, S_FILL, S_PAD, S_WRITE_REQ,
    S_WRITE_WAIT, S_NEXT, S_END_REQ, S_END_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d, req_nx;
  spi_pkg::cmd_t cmd_q, cmd_d, req_c;
  logic [23:0]   page_q, page_d;
  logic [7:0]    wr_ptr_q, wr_ptr_d, wdata;
  logic [15:0]   pw_q, pw_d;
  logic          last_q, last_d, done_q, done_d, err_q, err_d, we;
  logic [7:0]    mem [256];
  logic          unused_addr;

  // A command is only raised once the controller reports idle; otherwise the
  // REQ state holds NONE until cmd_done returns high.
  function automatic spi_pkg::cmd_t arm(input spi_pkg::cmd_t c, input logic idle);
    return idle ? c : spi_pkg::NONE;
  endfunction

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    page_d   = page_q;
    wr_ptr_d = wr_ptr_q;
    last_d   = last_q;
    pw_d     = pw_q;
    done_d   = done_q;
    err_d    = err_q;
    we       = 1'b0;
    wdata    = s_data;
    req_c    = spi_pkg::NONE;
    req_nx   = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        wr_ptr_d = 8'd0;
        page_d   = BASE_ADDR;
        pw_d     = 16'd0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        last_d   = 1'b0;
        if (ERASE_EN) begin
          state_d = S_ERASE_REQ;
          cmd_d   = arm(spi_pkg::ERASE, cmd_done);
        end else begin
          state_d = S_FILL;
        end
      end
      S_ERASE_REQ:  begin req_c = spi_pkg::ERASE; req_nx = S_ERASE_WAIT; end
      S_ERASE_WAIT: if (cmd_done) state_d = S_FILL;
      S_FILL: if (s_valid) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 8'd1;
        if (s_last) last_d = 1'b1;
        if (wr_ptr_q == 8'hFF) begin
          state_d = S_WRITE_REQ;
          cmd_d   = arm(spi_pkg::WRITE, cmd_done);
        end else if (s_last) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        we       = 1'b1;
        wdata    = PAD_BYTE;
        wr_ptr_d = wr_ptr_q + 8'd1;
        if (wr_ptr_q == 8'hFF) begin
          state_d = S_WRITE_REQ;
          cmd_d   = arm(spi_pkg::WRITE, cmd_done);
        end
      end
      S_WRITE_REQ:  begin req_c = spi_pkg::WRITE; req_nx = S_WRITE_WAIT; end
      S_WRITE_WAIT: if (cmd_done) state_d = S_NEXT;
      S_NEXT: begin
        pw_d     = (pw_q == 16'hFFFF) ? pw_q : pw_q + 16'd1;
        wr_ptr_d = 8'd0;
        if (last_q || page_q == 24'hFFFF00) begin
          err_d   = ~last_q | err_q;
          state_d = S_END_REQ;
          cmd_d   = arm(spi_pkg::END, cmd_done);
        end else begin
          page_d  = page_q + 24'h000100;
          state_d = S_FILL;
        end
      end
      S_END_REQ:  begin req_c = spi_pkg::END; req_nx = S_END_WAIT; end
      // The controller parks in END with cmd_done low for good.
      S_END_WAIT: if (!cmd_done) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
    if (req_c != spi_pkg::NONE) begin
      if (cmd_q == spi_pkg::NONE) begin
        if (cmd_done) cmd_d = req_c;
      end else if (!cmd_done) begin
        cmd_d   = spi_pkg::NONE;
        state_d = req_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= spi_pkg::NONE;
      page_q   <= BASE_ADDR;
      wr_ptr_q <= 8'd0;
      last_q   <= 1'b0;
      pw_q     <= 16'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      page_q   <= page_d;
      wr_ptr_q <= wr_ptr_d;
      last_q   <= last_d;
      pw_q     <= pw_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= wdata;
  end

  // Combinational read: the controller moves addr_out only a bit-time ahead.
  assign data_in       = mem[addr_out[7:0]];
  assign unused_addr   = ^addr_out[23:8];
  assign s_ready       = (state_q == S_FILL);
  assign cmd           = cmd_q;
  assign addr_in       = page_q;
  assign busy          = !(state_q inside {S_IDLE, S_DONE});
  assign done          = done_q;
  assign error         = err_q;
  assign pages_written = pw_q;
endmodule

// File: tb/tb_flash_page_writer.sv
// Directed bench: two writer instances share one behavioural SPI controller.
module tb_flash_page_writer;
  import spi_pkg::*;

  logic clk, n_rst, start, sel, s_valid, s_last;
  logic [7:0] s_data;
  logic [23:0] addr_out;
  logic cdone;

  cmd_t cmd_a, cmd_b, ctl_cmd;
  logic [23:0] addr_in_a, addr_in_b, ctl_addr;
  logic [7:0] data_a, data_b, ctl_data;
  logic rdy_a, rdy_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [15:0] pw_a, pw_b;

  flash_page_writer u_a (
    .clk(clk), .n_rst(n_rst), .start(start & ~sel), .s_data(s_data),
    .s_valid(s_valid & ~sel), .s_last(s_last), .s_ready(rdy_a), .cmd(cmd_a),
    .cmd_done(sel ? 1'b1 : cdone), .addr_in(addr_in_a), .addr_out(addr_out),
    .data_in(data_a), .busy(busy_a), .done(done_a), .error(err_a),
    .pages_written(pw_a));

  flash_page_writer #(.BASE_ADDR(24'hFFFF00), .ERASE_EN(1'b0)) u_b (
    .clk(clk), .n_rst(n_rst), .start(start & sel), .s_data(s_data),
    .s_valid(s_valid & sel), .s_last(s_last), .s_ready(rdy_b), .cmd(cmd_b),
    .cmd_done(sel ? cdone : 1'b1), .addr_in(addr_in_b), .addr_out(addr_out),
    .data_in(data_b), .busy(busy_b), .done(done_b), .error(err_b),
    .pages_written(pw_b));

  wire ctl_rdy  = sel ? rdy_b : rdy_a;
  wire ctl_busy = sel ? busy_b : busy_a;
  wire ctl_done = sel ? done_b : done_a;
  wire ctl_err  = sel ? err_b : err_a;
  wire [15:0] ctl_pw = sel ? pw_b : pw_a;
  assign ctl_cmd  = sel ? cmd_b : cmd_a;
  assign ctl_addr = sel ? addr_in_b : addr_in_a;
  assign ctl_data = sel ? data_b : data_a;

  int total = 0, bad = 0, cyc = 0, last_acc_cyc = 0, wr_cyc = 0;
  bit hung, rdy_bad, in_write;
  logic [7:0] img [int];
  logic [7:0] stim [$];
  cmd_t log_cmd [$];
  logic [23:0] log_addr [$];

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Controller model: samples cmd on the falling edge, reads the page through
  // addr_out/data_in while busy, parks forever on END.
  initial begin
    cdone = 1; hung = 0; addr_out = 0; rdy_bad = 0; in_write = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        cdone = 1; hung = 0; in_write = 0;
      end else if (!hung && cdone && ctl_cmd != NONE) begin
        log_cmd.push_back(ctl_cmd);
        log_addr.push_back(ctl_addr);
        cdone = 0;
        if (ctl_cmd == END) hung = 1;
        else if (ctl_cmd == ERASE) begin
          for (int k = 0; k < int'($urandom_range(2, 10)); k++) begin
            @(negedge clk);
            if (!n_rst) break;
          end
          cdone = 1;
        end else begin
          int base;
          bit ab;
          base = int'(ctl_addr); wr_cyc = cyc; in_write = 1; ab = 0;
          for (int i = 0; i < 256 && !ab; i++) begin
            @(negedge clk);
            if (!n_rst) ab = 1;
            else begin
              if (ctl_rdy) rdy_bad = 1;
              addr_out = 24'(i);
              #1 img[base + i] = ctl_data;
            end
          end
          for (int k = 0; k < int'($urandom_range(0, 30)) && !ab; k++) begin
            @(negedge clk);
            if (!n_rst) ab = 1;
            else if (ctl_rdy) rdy_bad = 1;
          end
          cdone = 1; in_write = 0;
        end
      end
    end
  end

  task automatic send(input int n, input bit rnd, input bit with_last, input int budget,
                      output int acc);
    int t;
    acc = 0; t = 0;
    while (acc < n && t < budget) begin
      @(negedge clk); t++;
      s_valid = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      s_data  = stim[acc];
      s_last  = with_last && (acc == n - 1);
      #1;
      if (s_valid && ctl_rdy) begin last_acc_cyc = cyc; acc++; end
    end
    @(negedge clk); s_valid = 0; s_last = 0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!ctl_done && t < 5000) begin @(negedge clk); t++; end
    chk(tag, ctl_done, 1);
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic do_reset;
    @(negedge clk); n_rst = 0;
    @(negedge clk); @(negedge clk); n_rst = 1;
    @(negedge clk);
    img.delete(); log_cmd.delete(); log_addr.delete(); stim.delete(); rdy_bad = 0;
  endtask

  task automatic cmp_img(input string tag, input int base, input int n);
    int nb;
    nb = 0;
    for (int i = 0; i < n; i++)
      if (!img.exists(base + i) || img[base + i] !== stim[i]) nb++;
    chk(tag, nb, 0);
  endtask

  task automatic cmp_pad(input string tag, input int base, input int from);
    int nb;
    nb = 0;
    for (int i = from; i < 256 * ((from + 255) / 256); i++)
      if (!img.exists(base + i) || img[base + i] !== 8'hFF) nb++;
    chk(tag, nb, 0);
  endtask

  initial begin
    int acc, t, n0;
    n_rst = 0; start = 0; sel = 0; s_valid = 0; s_last = 0; s_data = 0;
    #12;
    chk("rst_cmd", cmd_a, NONE);
    chk("rst_rdy", rdy_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_pw", pw_a, 0);
    chk("rst_addr_b", addr_in_b, 24'hFFFF00);
    do_reset();

    // Two full pages, erase enabled
    for (int i = 0; i < 512; i++) stim.push_back(i[7:0]);
    pulse_start();
    send(512, 0, 1, 5000, acc);
    chk("t1_acc", acc, 512);
    wait_done("t1_done");
    chk("t1_lat", wr_cyc - last_acc_cyc, 1);
    chk("t1_ncmd", log_cmd.size(), 4);
    chk("t1_c0", log_cmd[0], ERASE);
    chk("t1_c1", log_cmd[1], WRITE);
    chk("t1_a1", log_addr[1], 24'h000000);
    chk("t1_c2", log_cmd[2], WRITE);
    chk("t1_a2", log_addr[2], 24'h000100);
    chk("t1_c3", log_cmd[3], END);
    chk("t1_pw", ctl_pw, 2);
    chk("t1_busy", ctl_busy, 0);
    chk("t1_err", ctl_err, 0);
    cmp_img("t1_img", 0, 512);
    // start in DONE is ignored
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t6_done", ctl_done, 1);
    chk("t6_busy", ctl_busy, 0);
    chk("t6_ncmd", log_cmd.size(), 4);

    // Random valid gaps and controller latency, short final page
    do_reset();
    for (int i = 0; i < 600; i++) stim.push_back(8'($urandom));
    pulse_start();
    send(600, 1, 1, 10000, acc);
    chk("t3_acc", acc, 600);
    wait_done("t3_done");
    cmp_img("t3_img", 0, 600);
    cmp_pad("t3_pad", 0, 600);
    chk("t3_pw", ctl_pw, 3);
    chk("t3_rdy", rdy_bad, 0);
    chk("t3_ncmd", log_cmd.size(), 5);

    // Reset during WRITE_WAIT, then rerun
    do_reset();
    for (int i = 0; i < 256; i++) stim.push_back(8'(255 - i));
    pulse_start();
    send(256, 0, 0, 3000, acc);
    t = 0;
    while (!in_write && t < 500) begin @(negedge clk); t++; end
    chk("t5_inwr", in_write, 1);
    repeat (5) @(negedge clk);
    n_rst = 0;
    #1;
    chk("t5_cmd", cmd_a, NONE);
    chk("t5_busy", busy_a, 0);
    chk("t5_rdy", rdy_a, 0);
    @(negedge clk); @(negedge clk); n_rst = 1;
    @(negedge clk);
    img.delete(); log_cmd.delete(); log_addr.delete(); stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(8'(8'h30 + i));
    pulse_start();
    t = 0;
    while (!ctl_rdy && t < 200) begin @(negedge clk); t++; end
    chk("t5_fill", ctl_rdy, 1);
    n0 = log_cmd.size();
    pulse_start();
    repeat (2) @(negedge clk);
    chk("t6_fbusy", ctl_busy, 1);
    chk("t6_frdy", ctl_rdy, 1);
    chk("t6_fncmd", log_cmd.size(), n0);
    send(10, 0, 1, 2000, acc);
    wait_done("t5_done");
    chk("t5_c0", log_cmd[0], ERASE);
    chk("t5_c1", log_cmd[1], WRITE);
    chk("t5_a1", log_addr[1], 24'h000000);
    cmp_img("t5_img", 0, 10);

    // Three bytes, no erase, 253 pad cycles
    sel = 1;
    do_reset();
    stim.push_back(8'hA1); stim.push_back(8'hA2); stim.push_back(8'hA3);
    pulse_start();
    send(3, 0, 1, 500, acc);
    wait_done("t2_done");
    chk("t2_lat", wr_cyc - last_acc_cyc, 254);
    chk("t2_ncmd", log_cmd.size(), 2);
    chk("t2_c0", log_cmd[0], WRITE);
    chk("t2_a0", log_addr[0], 24'hFFFF00);
    chk("t2_c1", log_cmd[1], END);
    cmp_img("t2_img", 32'hFFFF00, 3);
    cmp_pad("t2_pad", 32'hFFFF00, 3);
    chk("t2_err", ctl_err, 0);

    // Address overflow at the top page
    do_reset();
    for (int i = 0; i < 300; i++) stim.push_back(8'(i * 7));
    pulse_start();
    send(300, 0, 0, 2000, acc);
    chk("t4_acc", acc, 256);
    wait_done("t4_done");
    chk("t4_err", ctl_err, 1);
    chk("t4_pw", ctl_pw, 1);
    chk("t4_ncmd", log_cmd.size(), 2);
    chk("t4_a0", log_addr[0], 24'hFFFF00);
    chk("t4_c1", log_cmd[1], END);
    cmp_img("t4_img", 32'hFFFF00, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
